// File: rtl/wb_hyperram_postbuf.sv
// Posted-write buffer in front of wb_hyperram: writes ack 1 cycle after queueing; reads wait until queued writes drain.
// Full FIFO stalls writes with no ack; HB_POSTBUF_STATS_EN adds saturating full-stall and read-wait counters.

module hb_postbuf_fifo #(
  parameter int W     = 68,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
endmodule

module wb_hyperram_postbuf #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic [LVL_W-1:0] level_o,
  output logic             busy_o
`ifdef HB_POSTBUF_STATS_EN
  ,
  output logic [15:0]      full_stalls_o,
  output logic [15:0]      rd_waits_o
`endif
);
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ, GAP} state_t;

  localparam int                ENTRY_W = $bits(entry_t);
  localparam logic [LVL_W-1:0]  FULL    = LVL_W'(DEPTH);

  state_t             state;
  entry_t             wr_entry;
  entry_t             head;
  logic [ENTRY_W-1:0] head_vec;
  logic [LVL_W-1:0]   count;
  logic               ack_q;
  logic               rd_pending;
  logic [31:0]        rd_adr;
  logic [3:0]         rd_sel;
  logic               req;
  logic               wr_req;
  logic               push;
  logic               pop;
  logic               rd_done;

  // Ack is gated by cyc so a master that abandons a read never sees a stray ack.
  assign wbs_ack_o = ack_q & wbs_cyc_i;
  assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_req    = req & wbs_we_i;
  assign push      = wr_req & (count < FULL);
  assign pop       = (state == WRITE) & wbm_ack_i;
  assign rd_done   = (state == READ) & wbm_ack_i;
  assign wr_entry  = '{adr: wbs_adr_i, dat: wbs_dat_i, sel: wbs_sel_i};
  assign head      = head_vec;
  assign level_o   = count;
  assign busy_o    = (count != '0) | wbm_cyc_o;

  hb_postbuf_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (LVL_W)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .head  (head_vec),
    .count (count)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      rd_pending <= 1'b0;
      rd_adr     <= '0;
      rd_sel     <= '0;
      wbs_dat_o  <= '0;
    end else begin
      ack_q <= push | (rd_done & wbs_cyc_i);
      if (rd_done) begin
        rd_pending <= 1'b0;
        wbs_dat_o  <= wbm_dat_i;
      end else if (req && !wbs_we_i && !rd_pending) begin
        rd_pending <= 1'b1;
        rd_adr     <= wbs_adr_i;
        rd_sel     <= wbs_sel_i;
      end
    end
  end

  // Queued writes always win over a pending read, which keeps reads ordered behind them.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= WRITE;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_sel_o <= head.sel;
            wbm_adr_o <= head.adr;
            wbm_dat_o <= head.dat;
          end else if (rd_pending) begin
            state     <= READ;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= rd_sel;
            wbm_adr_o <= rd_adr;
            wbm_dat_o <= '0;
          end
        end
        WRITE, READ: begin
          if (wbm_ack_i) begin
            state     <= GAP;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HB_POSTBUF_STATS_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      full_stalls_o <= '0;
      rd_waits_o    <= '0;
    end else begin
      if (wr_req && (count == FULL) && (full_stalls_o != 16'hFFFF))
        full_stalls_o <= full_stalls_o + 16'd1;
      if (rd_pending && (count != '0) && (rd_waits_o != 16'hFFFF))
        rd_waits_o <= rd_waits_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_hyperram_postbuf.sv
// Scoreboard bench for wb_hyperram_postbuf: directed upstream traffic, a latency-programmable downstream slave model.
module tb_wb_hyperram_postbuf;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [31:0]      wbs_adr_i, wbs_dat_i;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o, wbm_dat_o;
  logic             wbm_ack_i;
  logic [31:0]      wbm_dat_i;
  logic [LVL_W-1:0] level_o;
  logic             busy_o;
`ifdef HB_POSTBUF_STATS_EN
  logic [15:0]      full_stalls_o, rd_waits_o;
`endif

  wb_hyperram_postbuf #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .level_o   (level_o),
    .busy_o    (busy_o)
`ifdef HB_POSTBUF_STATS_EN
    ,
    .full_stalls_o (full_stalls_o),
    .rd_waits_o    (rd_waits_o)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } xact_t;

  xact_t       ds_q[$];
  xact_t       us_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          hold_ds = 0;
  int          ds_lat = 2;
  int          cyc_cnt = 0;
  int          rd_ack_cyc = 0;
  logic [31:0] ds_mem [logic [31:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_lvl(input string name, input int exp);
    @(negedge clk);
    chk(name, 72'(level_o), 72'(exp));
    step(1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
    xact_t x;
    x.we = 1'b1; x.adr = a; x.dat = d; x.sel = s;
    ds_q.push_back(x);
    us_q.push_back(x);
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    lat = 0;
    do begin
      step(1);
      lat++;
    end while (!wbs_ack_o && lat < 200);
    if (!wbs_ack_o) flag("wr_ack_timeout");
    step(1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp_dat);
    xact_t x;
    int n;
    x.we = 1'b0; x.adr = a; x.dat = exp_dat; x.sel = 4'hF;
    ds_q.push_back(x);
    us_q.push_back(x);
    wbs_adr_i = a; wbs_sel_i = 4'hF;
    wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!wbs_ack_o && n < 200);
    if (!wbs_ack_o) flag("rd_ack_timeout");
    step(1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  // Downstream read with no upstream ack expected (abandoned by the master).
  task automatic expect_ds_read(input logic [31:0] a);
    xact_t x;
    x.we = 1'b0; x.adr = a; x.dat = '0; x.sel = 4'hF;
    ds_q.push_back(x);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((ds_q.size() != 0 || busy_o) && n < 300) begin
      step(1);
      n++;
    end
    if (n >= 300) flag(name);
  endtask

  // Downstream slave model: acks after ds_lat cycles of cyc/stb unless held off.
  initial begin
    int wcnt;
    logic [31:0] cur;
    wcnt = 0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(posedge clk);
      #2;
      wbm_ack_i = 1'b0;
      if (rst_n && wbm_cyc_o && wbm_stb_o && !hold_ds) begin
        wcnt++;
        if (wcnt >= ds_lat) begin
          wbm_ack_i = 1'b1;
          wcnt = 0;
          cur = ds_mem.exists(wbm_adr_o) ? ds_mem[wbm_adr_o] : 32'h0;
          if (wbm_we_o) begin
            for (int b = 0; b < 4; b++)
              if (wbm_sel_o[b]) cur[b*8 +: 8] = wbm_dat_o[b*8 +: 8];
            ds_mem[wbm_adr_o] = cur;
          end else begin
            wbm_dat_i = cur;
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    xact_t e;
    cyc_cnt++;
    if (rst_n) begin
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
        if (ds_q.size() == 0) begin
          flag("ds_unexpected");
        end else begin
          e = ds_q.pop_front();
          if (e.we) begin
            chk("ds_write", 72'({wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}), 72'({e.we, e.sel, e.adr, e.dat}));
          end else begin
            chk("ds_read", 72'({wbm_we_o, wbm_sel_o, wbm_adr_o}), 72'({e.we, e.sel, e.adr}));
            rd_ack_cyc = cyc_cnt;
          end
        end
      end
      if (wbs_ack_o) begin
        if (us_q.size() == 0) begin
          flag("us_unexpected_ack");
        end else begin
          e = us_q.pop_front();
          if (!e.we) begin
            chk("us_rd_dat", 72'(wbs_dat_o), 72'(e.dat));
            chk("us_rd_ack_lat", 72'(cyc_cnt - rd_ack_cyc), 72'(1));
          end
        end
      end
    end
  end

  initial begin
    int lat, lat5, lat6;
    rst_n = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    #1;
    chk("rst_wbm", 72'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}), 72'(0));
    chk("rst_wbs", 72'({wbs_ack_o, wbs_dat_o, level_o, busy_o}), 72'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Single write, slow downstream
    ds_lat = 5;
    wb_write(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, lat);
    chk("t1_ack_lat", 72'(lat), 72'(1));
    chk_lvl("t1_level_one", 1);
    wait_drain("t1_drain");
    chk_lvl("t1_level_zero", 0);
    ds_lat = 2;

    // Fill FIFO with downstream stalled, then overflow
    hold_ds = 1;
    for (int i = 0; i < 4; i++)
      wb_write(32'h3000_0100 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF, lat);
    chk_lvl("t2_level_full", 4);
    wbs_adr_i = 32'h3000_0180; wbs_dat_i = 32'h5555_5555; wbs_sel_i = 4'hF;
    wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    step(10);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
`ifdef HB_POSTBUF_STATS_EN
    chk("t2_full_stalls", 72'(full_stalls_o), 72'(10));
`endif
    chk_lvl("t2_level_stalled", 4);
    fork
      begin
        wb_write(32'h3000_0110, 32'h1111_0004, 4'hF, lat5);
        wb_write(32'h3000_0114, 32'h1111_0005, 4'hF, lat6);
      end
      begin
        step(5);
        hold_ds = 0;
      end
    join
    chk("t2_fifth_stalled", 72'(lat5 >= 6), 72'(1));
    wait_drain("t2_drain");
    chk_lvl("t2_level_zero", 0);

    // Read ordered behind three queued writes
    hold_ds = 1;
    wb_write(32'h3000_0200, 32'h0102_0304, 4'hF, lat);
    wb_write(32'h3000_0204, 32'hA5A5_A5A5, 4'hF, lat);
    wb_write(32'h3000_0208, 32'hDEAD_BEEF, 4'hF, lat);
    chk_lvl("t3_level_three", 3);
    fork
      wb_read(32'h3000_0208, 32'hDEAD_BEEF);
      begin
        step(3);
        hold_ds = 0;
      end
    join
    wait_drain("t3_drain");

    // Master drops cyc mid-read: downstream completes, no upstream ack
    hold_ds = 1;
    expect_ds_read(32'h3000_0200);
    wbs_adr_i = 32'h3000_0200; wbs_sel_i = 4'hF;
    wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    step(3);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    step(2);
    hold_ds = 0;
    wait_drain("t3_abandon_drain");
    @(negedge clk);
    chk("t3_abandon_dat", 72'(wbs_dat_o), 72'(32'h0102_0304));
    step(1);

    // Master holds stb through the ack cycle: exactly one push
    hold_ds = 1;
    wb_write(32'h3000_0300, 32'hCAFE_F00D, 4'h3, lat);
    step(2);
    chk_lvl("t4_level_one", 1);
    hold_ds = 0;
    wait_drain("t4_drain");

    // Reset mid-downstream-write with two queued and a read pending
    hold_ds = 1;
    wb_write(32'h3000_0400, 32'h4444_0000, 4'hF, lat);
    wb_write(32'h3000_0404, 32'h4444_0001, 4'hF, lat);
    chk_lvl("t5_level_two", 2);
    wbs_adr_i = 32'h3000_0400; wbs_sel_i = 4'hF;
    wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    step(2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cyc", 72'({wbm_cyc_o, wbm_stb_o}), 72'(0));
    chk("t5_rst_level", 72'(level_o), 72'(0));
    chk("t5_rst_ack_busy", 72'({wbs_ack_o, busy_o}), 72'(0));
    ds_q.delete();
    us_q.delete();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_ds = 0;
    step(6);
    @(negedge clk);
    chk("t5_no_replay", 72'({wbm_cyc_o, level_o, busy_o}), 72'(0));
    step(1);

    // Fresh write after reset behaves like the first
    ds_lat = 5;
    wb_write(32'h3000_0010, 32'hDEAD_BEEF, 4'hF, lat);
    chk("t6_ack_lat", 72'(lat), 72'(1));
    chk_lvl("t6_level_one", 1);
    wait_drain("t6_drain");
    chk_lvl("t6_level_zero", 0);
    ds_lat = 2;

`ifdef HB_POSTBUF_STATS_EN
    chk("st_zero_after_rst", 72'({full_stalls_o, rd_waits_o}), 72'(0));
    hold_ds = 1;
    for (int i = 0; i < 4; i++)
      wb_write(32'h3000_0500 + 32'(i * 4), 32'h7777_0000 + 32'(i), 4'hF, lat);
    expect_ds_read(32'h3000_0208);
    wbs_adr_i = 32'h3000_0208; wbs_sel_i = 4'hF;
    wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    step(8);
    chk("st_rd_waits", 72'(rd_waits_o), 72'(7));
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    step(1);
    wbs_adr_i = 32'h3000_0580; wbs_dat_i = 32'h0; wbs_we_i = 1'b1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    step(70000);
    chk("st_full_sat", 72'(full_stalls_o), 72'(16'hFFFF));
    chk("st_rd_sat", 72'(rd_waits_o), 72'(16'hFFFF));
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    hold_ds = 0;
    wait_drain("st_drain");
`endif

    step(3);
    chk("end_us_q", 72'(us_q.size()), 72'(0));
    chk("end_ds_q", 72'(ds_q.size()), 72'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
